// File: rtl/dcache_tid_allocator.sv
// -----------------------------------------------------------------------------
// dcache_tid_allocator
//
// Hands out memory transaction IDs (TIDs) to the write-through data cache
// miss/store path and takes them back when the memory response returns.
// Two requesters share the pool: the load-miss path (index 0) and the store
// path (index 1). They are arbitrated round-robin, and the number of TIDs
// owned by stores is capped at MaxStores so that stores cannot starve loads
// of IDs.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset; discards every in-flight TID
//   req_i[1:0]     level request per requester (bit0 load, bit1 store)
//   gnt_o[1:0]     one-hot grant, combinational, same cycle as the request
//   tid_o          allocated TID, valid while |gnt_o
//   free_valid_i   a memory response retires free_tid_i this cycle
//   free_tid_i     TID being retired
//   busy_o         at least one TID in flight
//   full_o         no TID free
//   store_cnt_o    number of store-owned TIDs in flight
//   inflight_cnt_o total number of TIDs in flight
//   err_o          one-cycle pulse after a free of a TID that was not in flight
// -----------------------------------------------------------------------------
module dcache_tid_allocator #(
    parameter int TidWidth  = 4,
    parameter int MaxStores = 7
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [1:0]                     req_i,
    output logic [1:0]                     gnt_o,
    output logic [TidWidth-1:0]            tid_o,
    input  logic                           free_valid_i,
    input  logic [TidWidth-1:0]            free_tid_i,
    output logic                           busy_o,
    output logic                           full_o,
    output logic [$clog2(MaxStores+1)-1:0] store_cnt_o,
    output logic [TidWidth:0]              inflight_cnt_o,
    output logic                           err_o
);

    localparam int NrTids        = 2 ** TidWidth;
    localparam int StoreCntWidth = $clog2(MaxStores + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NrTids-1:0]        used_reg;
    logic [NrTids-1:0]        owner_reg;      // 1 = TID owned by a store
    logic [StoreCntWidth-1:0] store_cnt_reg;
    logic [TidWidth:0]        inflight_cnt_reg;
    logic                     rr_ptr_reg;     // requester preferred on contention
    logic                     err_reg;

    logic [NrTids-1:0]        used_next;
    logic [NrTids-1:0]        owner_next;
    logic [StoreCntWidth-1:0] store_cnt_next;
    logic [TidWidth:0]        inflight_cnt_next;
    logic                     rr_ptr_next;

    // ------------------------------------------------------------------
    // Eligibility and arbitration (registered state only, so a free in
    // this cycle can never unlock a grant in this same cycle).
    // ------------------------------------------------------------------
    logic                full;
    logic                store_room;
    logic                elig0;
    logic                elig1;
    logic                contention;
    logic [1:0]          gnt;
    logic                alloc;
    logic [TidWidth-1:0] alloc_tid;

    assign full       = &used_reg;
    assign store_room = store_cnt_reg < StoreCntWidth'(MaxStores);
    // rst_ni gates the grants so that asserting reset silences gnt_o at once,
    // even while a requester still holds its request line.
    assign elig0      = rst_ni & req_i[0] & ~full;
    assign elig1      = rst_ni & req_i[1] & ~full & store_room;
    assign contention = elig0 & elig1;

    always_comb begin
        gnt = {elig1, elig0};
        if (contention) begin
            gnt = rr_ptr_reg ? 2'b10 : 2'b01;
        end
    end

    assign alloc = |gnt;

    // Lowest-index free TID. Scanning downwards lets the last hit (the
    // lowest index) win without a separate found flag.
    always_comb begin
        alloc_tid = '0;
        for (int i = NrTids - 1; i >= 0; i--) begin
            if (!used_reg[i]) begin
                alloc_tid = i[TidWidth-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Retirement
    // ------------------------------------------------------------------
    logic free_ok;
    logic free_bad;
    logic store_alloc;
    logic store_free;

    assign free_ok     = free_valid_i & used_reg[free_tid_i];
    assign free_bad    = free_valid_i & ~used_reg[free_tid_i];
    assign store_alloc = alloc & gnt[1];
    assign store_free  = free_ok & owner_reg[free_tid_i];

    // Per-TID set/clear strobes. The TID being allocated is free and the
    // TID being retired is in flight, so the two never hit the same entry.
    logic [NrTids-1:0] alloc_hit;
    logic [NrTids-1:0] free_hit;

    for (genvar gi = 0; gi < NrTids; gi++) begin : g_tid
        assign alloc_hit[gi] = alloc   & (alloc_tid  == TidWidth'(gi));
        assign free_hit[gi]  = free_ok & (free_tid_i == TidWidth'(gi));
    end

    assign used_next  = (used_reg | alloc_hit) & ~free_hit;
    assign owner_next = (owner_reg & ~free_hit) | (alloc_hit & {NrTids{gnt[1]}});

    always_comb begin
        inflight_cnt_next = inflight_cnt_reg;
        if (alloc && !free_ok) begin
            inflight_cnt_next = inflight_cnt_reg + (TidWidth+1)'(1);
        end else if (!alloc && free_ok) begin
            inflight_cnt_next = inflight_cnt_reg - (TidWidth+1)'(1);
        end
    end

    always_comb begin
        store_cnt_next = store_cnt_reg;
        if (store_alloc && !store_free) begin
            store_cnt_next = store_cnt_reg + StoreCntWidth'(1);
        end else if (!store_alloc && store_free) begin
            store_cnt_next = store_cnt_reg - StoreCntWidth'(1);
        end
    end

    // The winner of a contended round becomes the loser's turn next time;
    // uncontended grants leave the pointer alone.
    assign rr_ptr_next = contention ? ~rr_ptr_reg : rr_ptr_reg;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            used_reg         <= '0;
            owner_reg        <= '0;
            store_cnt_reg    <= '0;
            inflight_cnt_reg <= '0;
            rr_ptr_reg       <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            used_reg         <= used_next;
            owner_reg        <= owner_next;
            store_cnt_reg    <= store_cnt_next;
            inflight_cnt_reg <= inflight_cnt_next;
            rr_ptr_reg       <= rr_ptr_next;
            err_reg          <= free_bad;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt_o          = gnt;
    assign tid_o          = alloc_tid;
    assign busy_o         = |used_reg;
    assign full_o         = full;
    assign store_cnt_o    = store_cnt_reg;
    assign inflight_cnt_o = inflight_cnt_reg;
    assign err_o          = err_reg;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(gnt_o));
    a_gnt_has_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (gnt_o & ~req_i) == 2'b00);
    a_inflight_cnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(inflight_cnt_reg) == $countones(used_reg));
    a_store_cnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(store_cnt_reg) == $countones(used_reg & owner_reg));
    a_store_cap : assert property (@(posedge clk_i) disable iff (!rst_ni)
        int'(store_cnt_reg) <= MaxStores);

endmodule

// File: tb/tb_dcache_tid_allocator.sv
// -----------------------------------------------------------------------------
// tb_dcache_tid_allocator
//
// Self-checking bench for dcache_tid_allocator: a table of directed vectors,
// hand-written sequences for the store cap, the full pool, invalid frees and
// asynchronous reset, then randomized traffic compared every cycle against a
// pool model built from plain per-TID arrays.
// -----------------------------------------------------------------------------
module tb_dcache_tid_allocator;

    localparam int TW   = 4;
    localparam int NR   = 16;
    localparam int MAXS = 7;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [1:0]    req_i;
    logic [1:0]    gnt_o;
    logic [TW-1:0] tid_o;
    logic          free_valid_i;
    logic [TW-1:0] free_tid_i;
    logic          busy_o;
    logic          full_o;
    logic [2:0]    store_cnt_o;
    logic [TW:0]   inflight_cnt_o;
    logic          err_o;

    dcache_tid_allocator #(.TidWidth(TW), .MaxStores(MAXS)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .gnt_o          (gnt_o),
        .tid_o          (tid_o),
        .free_valid_i   (free_valid_i),
        .free_tid_i     (free_tid_i),
        .busy_o         (busy_o),
        .full_o         (full_o),
        .store_cnt_o    (store_cnt_o),
        .inflight_cnt_o (inflight_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: which TIDs are out, who owns them, whose turn it is.
    // ------------------------------------------------------------------
    bit       m_used[NR];
    bit       m_owner[NR];
    bit       m_rr;
    bit       m_err;
    bit       m_both;
    bit [1:0] e_gnt;
    int       e_tid;

    function automatic int m_inflight();
        int n = 0;
        for (int i = 0; i < NR; i++) n += m_used[i];
        return n;
    endfunction

    function automatic int m_stores();
        int n = 0;
        for (int i = 0; i < NR; i++) n += (m_used[i] && m_owner[i]) ? 1 : 0;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_used[i]  = 1'b0;
            m_owner[i] = 1'b0;
        end
        m_rr  = 1'b0;
        m_err = 1'b0;
    endtask

    // Expected grant for the current inputs and pool contents.
    task automatic model_eval();
        bit full, e0, e1;
        full   = (m_inflight() == NR);
        e0     = req_i[0] && !full;
        e1     = req_i[1] && !full && (m_stores() < MAXS);
        m_both = e0 && e1;
        if (m_both) e_gnt = m_rr ? 2'b10 : 2'b01;
        else        e_gnt = {e1, e0};
        e_tid = 0;
        for (int i = NR - 1; i >= 0; i--) if (!m_used[i]) e_tid = i;
    endtask

    // Clock-edge effect of the cycle just evaluated.
    task automatic model_commit();
        int  f   = int'(free_tid_i);
        bit  was = m_used[f];
        if (e_gnt != 2'b00) begin
            m_used[e_tid]  = 1'b1;
            m_owner[e_tid] = e_gnt[1];
        end
        if (m_both) m_rr = (e_gnt == 2'b01);
        m_err = free_valid_i && !was;
        if (free_valid_i && was) begin
            m_used[f]  = 1'b0;
            m_owner[f] = 1'b0;
        end
    endtask

    // Drive inputs just after a falling edge and sample 1ns later.
    task automatic apply(input logic [1:0] r, input bit fv, input int ft);
        req_i        = r;
        free_valid_i = fv;
        free_tid_i   = TW'(ft);
        #1;
        model_eval();
        $display("[%0t] req=%b free=%b/%0d gnt=%b tid=%0d infl=%0d st=%0d full=%b err=%b",
                 $time, r, fv, ft, gnt_o, tid_o, inflight_cnt_o, store_cnt_o, full_o, err_o);
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_commit();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni       = 1'b0;
        req_i        = 2'b00;
        free_valid_i = 1'b0;
        free_tid_i   = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".gnt"}, int'(gnt_o), int'(e_gnt));
        if (e_gnt != 2'b00) chk({tag, ".tid"}, int'(tid_o), e_tid);
        chk({tag, ".busy"}, int'(busy_o), (m_inflight() != 0) ? 1 : 0);
        chk({tag, ".full"}, int'(full_o), (m_inflight() == NR) ? 1 : 0);
        chk({tag, ".infl"}, int'(inflight_cnt_o), m_inflight());
        chk({tag, ".store"}, int'(store_cnt_o), m_stores());
        chk({tag, ".err"}, int'(err_o), int'(m_err));
    endtask

    // ------------------------------------------------------------------
    // Directed vectors from reset: contention, invalid and double free.
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0] req;
        bit         fv;
        int         ftid;
        logic [1:0] gnt;
        int         tid;
        int         infl;
        int         st;
        bit         err;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int pick;

        tbl[0] = '{2'b11, 1'b0, 0, 2'b01, 0, 0, 0, 1'b0};
        tbl[1] = '{2'b11, 1'b0, 0, 2'b10, 1, 1, 0, 1'b0};
        tbl[2] = '{2'b11, 1'b0, 0, 2'b01, 2, 2, 1, 1'b0};
        tbl[3] = '{2'b11, 1'b0, 0, 2'b10, 3, 3, 1, 1'b0};
        tbl[4] = '{2'b00, 1'b1, 9, 2'b00, 0, 4, 2, 1'b0};  // TID 9 never issued
        tbl[5] = '{2'b00, 1'b1, 0, 2'b00, 0, 4, 2, 1'b1};  // err from TID 9; free 0
        tbl[6] = '{2'b00, 1'b1, 0, 2'b00, 0, 3, 2, 1'b0};  // free 0 a second time
        tbl[7] = '{2'b01, 1'b0, 0, 2'b01, 0, 3, 2, 1'b1};  // err from double free
        tbl[8] = '{2'b00, 1'b0, 0, 2'b00, 0, 4, 2, 1'b0};

        // Reset state.
        do_reset();
        apply(2'b00, 1'b0, 0);
        chk("rst.gnt", int'(gnt_o), 0);
        chk("rst.busy", int'(busy_o), 0);
        chk("rst.full", int'(full_o), 0);
        chk("rst.infl", int'(inflight_cnt_o), 0);
        chk("rst.store", int'(store_cnt_o), 0);
        chk("rst.err", int'(err_o), 0);

        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].req, tbl[i].fv, tbl[i].ftid);
            chk($sformatf("vec%0d.gnt", i), int'(gnt_o), int'(tbl[i].gnt));
            if (tbl[i].gnt != 2'b00) chk($sformatf("vec%0d.tid", i), int'(tid_o), tbl[i].tid);
            chk($sformatf("vec%0d.infl", i), int'(inflight_cnt_o), tbl[i].infl);
            chk($sformatf("vec%0d.store", i), int'(store_cnt_o), tbl[i].st);
            chk($sformatf("vec%0d.err", i), int'(err_o), int'(tbl[i].err));
            advance();
        end

        // Loads only: TIDs 0,1,2 in order.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(2'b01, 1'b0, 0);
            chk("load.gnt", int'(gnt_o), 1);
            chk("load.tid", int'(tid_o), i);
            advance();
        end
        apply(2'b00, 1'b0, 0);
        chk("load.infl", int'(inflight_cnt_o), 3);
        chk("load.store", int'(store_cnt_o), 0);
        chk("load.busy", int'(busy_o), 1);
        advance();

        // Store cap: seven grants out of ten cycles, then a free reopens it.
        do_reset();
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            apply(2'b10, 1'b0, 0);
            if (gnt_o == 2'b10) begin
                chk("cap.tid", int'(tid_o), grants);
                grants++;
            end
            advance();
        end
        chk("cap.grants", grants, MAXS);
        apply(2'b10, 1'b1, 3);
        chk("cap.freecyc.gnt", int'(gnt_o), 0);
        chk("cap.freecyc.store", int'(store_cnt_o), 7);
        advance();
        apply(2'b10, 1'b0, 0);
        chk("cap.regrant.gnt", int'(gnt_o), 2);
        chk("cap.regrant.tid", int'(tid_o), 3);
        chk("cap.regrant.store", int'(store_cnt_o), 6);
        advance();
        apply(2'b00, 1'b0, 0);
        chk("cap.after.store", int'(store_cnt_o), 7);
        advance();

        // Full pool: a same-cycle free does not enable a grant.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            apply(2'b01, 1'b0, 0);
            advance();
        end
        apply(2'b01, 1'b1, 5);
        chk("full.full", int'(full_o), 1);
        chk("full.gnt", int'(gnt_o), 0);
        chk("full.infl", int'(inflight_cnt_o), 16);
        advance();
        apply(2'b01, 1'b0, 0);
        chk("full.next.gnt", int'(gnt_o), 1);
        chk("full.next.tid", int'(tid_o), 5);
        chk("full.next.infl", int'(inflight_cnt_o), 15);
        chk("full.next.full", int'(full_o), 0);
        advance();
        apply(2'b00, 1'b0, 0);
        chk("full.refill.infl", int'(inflight_cnt_o), 16);
        chk("full.refill.full", int'(full_o), 1);
        advance();

        // Asynchronous reset mid-cycle while a request is still held.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(2'b01, 1'b0, 0);
            advance();
        end
        apply(2'b01, 1'b0, 0);
        chk("arst.pre.gnt", int'(gnt_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst.gnt", int'(gnt_o), 0);
        chk("arst.busy", int'(busy_o), 0);
        chk("arst.infl", int'(inflight_cnt_o), 0);
        chk("arst.store", int'(store_cnt_o), 0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply(2'b01, 1'b1, 3);   // late free of a TID discarded by reset
        chk("arst.first.tid", int'(tid_o), 0);
        compare_all("arst.first");
        advance();
        apply(2'b00, 1'b0, 0);
        chk("arst.latefree.err", int'(err_o), 1);
        compare_all("arst.latefree");
        advance();

        // Randomized traffic against the model; free rate rises halfway.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bit fv;
            fv   = ($urandom_range(0, 99) < ((n < 200) ? 20 : 45));
            pick = $urandom_range(0, NR - 1);
            // Mostly free something that is really out; sometimes any TID.
            if ($urandom_range(0, 3) != 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (m_used[(pick + k) % NR]) begin
                        pick = (pick + k) % NR;
                        break;
                    end
                end
            end
            apply(2'($urandom_range(0, 3)), fv, pick);
            compare_all($sformatf("rand%0d", n));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
